// File: rtl/cpu_bus_bridge_if.sv
// CPU-side four-phase bus handshake between the CPU core (master) and the bridge (slave).
interface cpu_bus_bridge_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (output req, we, addr, wdata, input rdata, ready);
  modport slave  (input req, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/cpu_bus_bridge.sv
// Bridge from the CPU four-phase bus to a sync-read RAM port, a waited I/O window,
// or unmapped space (sticky error, fixed read value).
module cpu_bus_bridge #(
  parameter int unsigned       DATA_W       = 32,
  parameter int unsigned       ADDR_W       = 32,
  parameter int unsigned       RAM_AW       = 16,
  parameter int unsigned       MEM_LAT      = 1,
  parameter logic [ADDR_W-1:0] IO_BASE      = 32'h0001_FF00,
  parameter int unsigned       IO_WAIT      = 2,
  parameter logic [DATA_W-1:0] UNMAPPED_VAL = 32'hFFFF_FFFF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  cpu_bus_bridge_if.slave      cpu,
  output logic                 o_mem_en,
  output logic                 o_mem_we,
  output logic [RAM_AW-1:0]    o_mem_addr,
  output logic [DATA_W-1:0]    o_mem_wdata,
  input  logic [DATA_W-1:0]    i_mem_rdata,
  output logic                 o_io_rd,
  output logic                 o_io_wr,
  output logic [7:0]           o_io_addr,
  output logic [DATA_W-1:0]    o_io_wdata,
  input  logic [DATA_W-1:0]    i_io_rdata,
  output logic                 o_bus_err,
  input  logic                 i_err_clr
);

  typedef enum logic [2:0] {S_IDLE, S_RAM_WAIT, S_IO_WAIT, S_IO_CAP, S_ACK} state_t;

  localparam logic [3:0] MEM_LAT_C = 4'(MEM_LAT);
  localparam logic [3:0] IO_WAIT_C = 4'(IO_WAIT);

  state_t              state, state_n;
  logic [3:0]          cnt, cnt_n;
  logic                we_q, we_n;
  logic [DATA_W-1:0]   rdata_q, rdata_n;
  logic                ready_q, ready_n;
  logic                err_q, err_n;
  logic                mem_en_n, mem_we_n;
  logic [RAM_AW-1:0]   mem_addr_n;
  logic [DATA_W-1:0]   mem_wdata_n;
  logic                io_rd_n, io_wr_n;
  logic [7:0]          io_addr_n;
  logic [DATA_W-1:0]   io_wdata_n;
  logic                is_ram, is_io;

  assign is_ram = (cpu.addr[ADDR_W-1:RAM_AW] == '0);
  assign is_io  = (cpu.addr[ADDR_W-1:8] == IO_BASE[ADDR_W-1:8]);

  assign cpu.rdata = rdata_q;
  assign cpu.ready = ready_q;
  assign o_bus_err = err_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      we_q        <= 1'b0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      o_mem_en    <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_io_rd     <= 1'b0;
      o_io_wr     <= 1'b0;
      o_io_addr   <= '0;
      o_io_wdata  <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      we_q        <= we_n;
      rdata_q     <= rdata_n;
      ready_q     <= ready_n;
      err_q       <= err_n;
      o_mem_en    <= mem_en_n;
      o_mem_we    <= mem_we_n;
      o_mem_addr  <= mem_addr_n;
      o_mem_wdata <= mem_wdata_n;
      o_io_rd     <= io_rd_n;
      o_io_wr     <= io_wr_n;
      o_io_addr   <= io_addr_n;
      o_io_wdata  <= io_wdata_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    we_n        = we_q;
    rdata_n     = rdata_q;
    ready_n     = ready_q;
    // a set on this edge overrides a simultaneous clear
    err_n       = err_q & ~i_err_clr;
    mem_en_n    = 1'b0;
    mem_we_n    = o_mem_we;
    mem_addr_n  = o_mem_addr;
    mem_wdata_n = o_mem_wdata;
    io_rd_n     = 1'b0;
    io_wr_n     = 1'b0;
    io_addr_n   = o_io_addr;
    io_wdata_n  = o_io_wdata;

    case (state)
      S_IDLE: begin
        if (cpu.req) begin
          we_n = cpu.we;
          if (is_ram) begin
            mem_en_n    = 1'b1;
            mem_we_n    = cpu.we;
            mem_addr_n  = cpu.addr[RAM_AW-1:0];
            mem_wdata_n = cpu.wdata;
            cnt_n       = MEM_LAT_C;
            state_n     = S_RAM_WAIT;
          end else if (is_io) begin
            io_addr_n  = cpu.addr[7:0];
            io_wdata_n = cpu.wdata;
            if (IO_WAIT == 0) begin
              io_rd_n = ~cpu.we;
              io_wr_n = cpu.we;
              state_n = S_IO_CAP;
            end else begin
              cnt_n   = IO_WAIT_C;
              state_n = S_IO_WAIT;
            end
          end else begin
            ready_n = 1'b1;
            err_n   = 1'b1;
            if (!cpu.we) rdata_n = UNMAPPED_VAL;
            state_n = S_ACK;
          end
        end
      end
      S_RAM_WAIT: begin
        if (cnt == 4'd1) begin
          if (!we_q) rdata_n = i_mem_rdata;
          ready_n = 1'b1;
          cnt_n   = '0;
          state_n = S_ACK;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      S_IO_WAIT: begin
        if (cnt == 4'd1) begin
          io_rd_n = ~we_q;
          io_wr_n = we_q;
          cnt_n   = '0;
          state_n = S_IO_CAP;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      S_IO_CAP: begin
        if (!we_q) rdata_n = i_io_rdata;
        ready_n = 1'b1;
        state_n = S_ACK;
      end
      S_ACK: begin
        if (!cpu.req) begin
          ready_n = 1'b0;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// Two bridges (MEM_LAT=1/IO_WAIT=2 and MEM_LAT=3/IO_WAIT=0) share one stimulus stream
// and are checked every cycle against a transaction-schedule model.
module tb_cpu_bus_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0, req = 1'b0, we = 1'b0, err_clr = 1'b0;
  logic [31:0] addr = '0, wdata = '0, mem_rdata = '0, io_rdata = '0;

  cpu_bus_bridge_if #(.DATA_W(32), .ADDR_W(32)) cif0 ();
  cpu_bus_bridge_if #(.DATA_W(32), .ADDR_W(32)) cif1 ();

  assign cif0.req = req;  assign cif0.we = we;  assign cif0.addr = addr;  assign cif0.wdata = wdata;
  assign cif1.req = req;  assign cif1.we = we;  assign cif1.addr = addr;  assign cif1.wdata = wdata;

  logic        mem_en [2], mem_we [2], io_rd [2], io_wr [2], bus_err [2], ready [2];
  logic [15:0] mem_addr [2];
  logic [31:0] mem_wdata [2], io_wdata [2], rdata [2];
  logic [7:0]  io_addr [2];

  assign rdata[0] = cif0.rdata;  assign ready[0] = cif0.ready;
  assign rdata[1] = cif1.rdata;  assign ready[1] = cif1.ready;

  cpu_bus_bridge #(.MEM_LAT(1), .IO_WAIT(2)) dut0 (
    .i_clk(clk), .i_rst(rst), .cpu(cif0.slave),
    .o_mem_en(mem_en[0]), .o_mem_we(mem_we[0]), .o_mem_addr(mem_addr[0]),
    .o_mem_wdata(mem_wdata[0]), .i_mem_rdata(mem_rdata),
    .o_io_rd(io_rd[0]), .o_io_wr(io_wr[0]), .o_io_addr(io_addr[0]),
    .o_io_wdata(io_wdata[0]), .i_io_rdata(io_rdata),
    .o_bus_err(bus_err[0]), .i_err_clr(err_clr)
  );

  cpu_bus_bridge #(.MEM_LAT(3), .IO_WAIT(0)) dut1 (
    .i_clk(clk), .i_rst(rst), .cpu(cif1.slave),
    .o_mem_en(mem_en[1]), .o_mem_we(mem_we[1]), .o_mem_addr(mem_addr[1]),
    .o_mem_wdata(mem_wdata[1]), .i_mem_rdata(mem_rdata),
    .o_io_rd(io_rd[1]), .o_io_wr(io_wr[1]), .o_io_addr(io_addr[1]),
    .o_io_wdata(io_wdata[1]), .i_io_rdata(io_rdata),
    .o_bus_err(bus_err[1]), .i_err_clr(err_clr)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: one transaction record per bridge ----------------
  localparam int KIND_RAM = 0, KIND_IO = 1, KIND_UNM = 2;
  int unsigned lat_p [2] = '{1, 3};
  int unsigned iow_p [2] = '{2, 0};

  int unsigned e = 0;
  bit          started = 1'b0;
  bit          m_busy [2] = '{0, 0};
  bit          m_we [2] = '{0, 0};
  bit          m_ready [2] = '{0, 0};
  bit          m_err [2] = '{0, 0};
  bit          m_inrst [2] = '{0, 0};
  int          m_kind [2] = '{0, 0};
  int unsigned m_t0 [2] = '{0, 0};
  int unsigned m_str [2] = '{0, 0};
  int unsigned m_rdy [2] = '{0, 0};
  logic [31:0] m_addr [2] = '{0, 0};
  logic [31:0] m_wdata [2] = '{0, 0};
  logic [31:0] m_rdata [2] = '{0, 0};

  function automatic int classify(input logic [31:0] a);
    if (a < 32'h0001_0000) return KIND_RAM;
    if ((a >> 8) == (32'h0001_FF00 >> 8)) return KIND_IO;
    return KIND_UNM;
  endfunction

  task automatic model_step();
    bit err_set;
    e++;
    started = 1'b1;
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        m_inrst[d] = 1'b1;
        m_busy[d]  = 1'b0;
        m_ready[d] = 1'b0;
        m_err[d]   = 1'b0;
        m_rdata[d] = '0;
      end else begin
        m_inrst[d] = 1'b0;
        err_set = 1'b0;
        if (m_busy[d] && e > m_rdy[d] && !req) begin
          m_busy[d]  = 1'b0;
          m_ready[d] = 1'b0;
        end else if (!m_busy[d] && req) begin
          m_busy[d]  = 1'b1;
          m_t0[d]    = e;
          m_we[d]    = we;
          m_addr[d]  = addr;
          m_wdata[d] = wdata;
          m_kind[d]  = classify(addr);
          m_str[d]   = e + ((m_kind[d] == KIND_IO) ? iow_p[d] : 0);
          case (m_kind[d])
            KIND_RAM: m_rdy[d] = e + lat_p[d];
            KIND_IO:  m_rdy[d] = e + iow_p[d] + 1;
            default:  m_rdy[d] = e;
          endcase
          if (m_kind[d] == KIND_UNM) err_set = 1'b1;
        end
        if (m_busy[d] && e == m_rdy[d]) begin
          m_ready[d] = 1'b1;
          if (!m_we[d])
            m_rdata[d] = (m_kind[d] == KIND_RAM) ? mem_rdata :
                         (m_kind[d] == KIND_IO)  ? io_rdata  : 32'hFFFF_FFFF;
        end
        if (err_set) m_err[d] = 1'b1;
        else if (err_clr) m_err[d] = 1'b0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (started) begin
      for (int d = 0; d < 2; d++) begin
        bit x_mem, x_rd, x_wr;
        x_mem = m_busy[d] && m_kind[d] == KIND_RAM && e == m_t0[d];
        x_rd  = m_busy[d] && m_kind[d] == KIND_IO && !m_we[d] && e == m_str[d];
        x_wr  = m_busy[d] && m_kind[d] == KIND_IO &&  m_we[d] && e == m_str[d];
        check($sformatf("d%0d ready", d), 32'(ready[d]), 32'(m_ready[d]));
        check($sformatf("d%0d rdata", d), rdata[d], m_rdata[d]);
        check($sformatf("d%0d bus_err", d), 32'(bus_err[d]), 32'(m_err[d]));
        check($sformatf("d%0d mem_en", d), 32'(mem_en[d]), 32'(x_mem));
        check($sformatf("d%0d io_rd", d), 32'(io_rd[d]), 32'(x_rd));
        check($sformatf("d%0d io_wr", d), 32'(io_wr[d]), 32'(x_wr));
        if (x_mem) begin
          check($sformatf("d%0d mem_we", d), 32'(mem_we[d]), 32'(m_we[d]));
          check($sformatf("d%0d mem_addr", d), 32'(mem_addr[d]), 32'(m_addr[d][15:0]));
          check($sformatf("d%0d mem_wdata", d), mem_wdata[d], m_wdata[d]);
        end
        if (x_rd || x_wr) begin
          check($sformatf("d%0d io_addr", d), 32'(io_addr[d]), 32'(m_addr[d][7:0]));
          check($sformatf("d%0d io_wdata", d), io_wdata[d], m_wdata[d]);
        end
        if (m_inrst[d]) begin
          check($sformatf("d%0d rst mem_addr", d), 32'(mem_addr[d]), 32'h0);
          check($sformatf("d%0d rst mem_wdata", d), mem_wdata[d], 32'h0);
          check($sformatf("d%0d rst io_addr", d), 32'(io_addr[d]), 32'h0);
          check($sformatf("d%0d rst io_wdata", d), io_wdata[d], 32'h0);
          check($sformatf("d%0d rst mem_we", d), 32'(mem_we[d]), 32'h0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) tick();
  endtask

  task automatic start(input bit w, input logic [31:0] a, input logic [31:0] wd);
    req = 1'b1; we = w; addr = a; wdata = wd;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 6))
      0, 1:    return {16'h0, r[15:0]};
      2:       return 32'h0000_FFFF;
      3:       return 32'h0001_0000;
      4:       return {24'h0001FF, r[7:0]};
      5:       return ($urandom_range(0, 1) != 0) ? 32'h0001_FEFF : 32'h0002_0000;
      default: return r;
    endcase
  endfunction

  int pulses;

  initial begin
    rst = 1'b0;
    repeat (3) tick();
    check("reset ready", 32'(ready[0]), 32'h0);
    check("reset rdata", rdata[0], 32'h0);
    check("reset bus_err", 32'(bus_err[0]), 32'h0);
    rst = 1'b1;
    tick();

    // RAM read 0x10
    mem_rdata = 32'hDEAD_BEEF;
    start(1'b0, 32'h0000_0010, 32'h0);
    tick();
    check("ram rd E0 mem_en", 32'(mem_en[0]), 32'h1);
    check("ram rd E0 mem_addr", 32'(mem_addr[0]), 32'h10);
    check("ram rd E0 mem_we", 32'(mem_we[0]), 32'h0);
    check("ram rd E0 ready", 32'(ready[0]), 32'h0);
    tick();
    check("ram rd E1 ready", 32'(ready[0]), 32'h1);
    check("ram rd E1 rdata", rdata[0], 32'hDEAD_BEEF);
    check("ram rd E1 mem_en", 32'(mem_en[0]), 32'h0);
    tick();
    check("ram rd hold rdata", rdata[0], 32'hDEAD_BEEF);
    req = 1'b0;
    tick();
    check("ram rd ready fall", 32'(ready[0]), 32'h0);
    check("ram rd lat3 ready", 32'(ready[1]), 32'h1);
    check("ram rd lat3 rdata", rdata[1], 32'hDEAD_BEEF);
    idle(3);

    // RAM write 0xFFFF
    start(1'b1, 32'h0000_FFFF, 32'h1234_5678);
    tick();
    check("ram wr mem_en", 32'(mem_en[0]), 32'h1);
    check("ram wr mem_we", 32'(mem_we[0]), 32'h1);
    check("ram wr mem_addr", 32'(mem_addr[0]), 32'hFFFF);
    check("ram wr mem_wdata", mem_wdata[0], 32'h1234_5678);
    tick();
    check("ram wr ready", 32'(ready[0]), 32'h1);
    check("ram wr rdata kept", rdata[0], 32'hDEAD_BEEF);
    idle(4);

    // I/O read 0x1FF05
    io_rdata = 32'h0000_00A5;
    start(1'b0, 32'h0001_FF05, 32'h0);
    tick();
    check("io E0 io_rd w2", 32'(io_rd[0]), 32'h0);
    check("io E0 io_rd w0", 32'(io_rd[1]), 32'h1);
    check("io E0 io_addr w0", 32'(io_addr[1]), 32'h05);
    tick();
    check("io E1 io_rd w2", 32'(io_rd[0]), 32'h0);
    check("io E1 ready w0", 32'(ready[1]), 32'h1);
    check("io E1 rdata w0", rdata[1], 32'h0000_00A5);
    tick();
    check("io E2 io_rd w2", 32'(io_rd[0]), 32'h1);
    check("io E2 io_addr w2", 32'(io_addr[0]), 32'h05);
    check("io E2 ready w2", 32'(ready[0]), 32'h0);
    tick();
    check("io E3 io_rd w2", 32'(io_rd[0]), 32'h0);
    check("io E3 ready w2", 32'(ready[0]), 32'h1);
    check("io E3 rdata w2", rdata[0], 32'h0000_00A5);
    idle(3);

    // unmapped read, then set-vs-clear, then clear alone
    start(1'b0, 32'h0800_0000, 32'h0);
    tick();
    check("unm ready", 32'(ready[0]), 32'h1);
    check("unm rdata", rdata[0], 32'hFFFF_FFFF);
    check("unm bus_err", 32'(bus_err[0]), 32'h1);
    idle(2);
    start(1'b0, 32'h0800_0000, 32'h0);
    err_clr = 1'b1;
    tick();
    check("unm set wins", 32'(bus_err[0]), 32'h1);
    err_clr = 1'b0;
    idle(2);
    check("err sticky", 32'(bus_err[0]), 32'h1);
    err_clr = 1'b1;
    tick();
    check("err cleared", 32'(bus_err[0]), 32'h0);
    err_clr = 1'b0;
    idle(1);

    // back-to-back with req held across ACK
    pulses = 0;
    mem_rdata = 32'h1111_1111;
    start(1'b0, 32'h0000_0020, 32'h0);
    repeat (4) begin tick(); pulses += int'(mem_en[0]); end
    check("b2b held ready", 32'(ready[0]), 32'h1);
    req = 1'b0;
    tick(); pulses += int'(mem_en[0]);
    check("b2b ready low", 32'(ready[0]), 32'h0);
    mem_rdata = 32'h2222_2222;
    start(1'b0, 32'h0000_0024, 32'h0);
    tick(); pulses += int'(mem_en[0]);
    check("b2b 2nd mem_en", 32'(mem_en[0]), 32'h1);
    check("b2b 2nd mem_addr", 32'(mem_addr[0]), 32'h24);
    tick(); pulses += int'(mem_en[0]);
    check("b2b 2nd rdata", rdata[0], 32'h2222_2222);
    req = 1'b0;
    repeat (5) begin tick(); pulses += int'(mem_en[0]); end
    check("b2b pulse count", 32'(pulses), 32'd2);

    // reset during I/O wait
    start(1'b0, 32'h0001_FF10, 32'h0);
    tick();
    rst = 1'b0; req = 1'b0;
    tick();
    rst = 1'b1;
    pulses = 0;
    repeat (4) begin tick(); pulses += int'(io_rd[0]); end
    check("rst io_rd pulses", 32'(pulses), 32'd0);
    check("rst ready", 32'(ready[0]), 32'h0);
    check("rst rdata", rdata[0], 32'h0);
    mem_rdata = 32'hCAFE_F00D;
    start(1'b0, 32'h0000_0040, 32'h0);
    tick();
    tick();
    check("post-rst ready", 32'(ready[0]), 32'h1);
    check("post-rst rdata", rdata[0], 32'hCAFE_F00D);
    idle(4);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 2) == 0) req = ~req;
      we        = $urandom_range(0, 1);
      addr      = rand_addr();
      wdata     = $urandom;
      mem_rdata = $urandom;
      io_rdata  = $urandom;
      err_clr   = ($urandom_range(0, 9) == 0);
      tick();
    end
    rst = 1'b1; err_clr = 1'b0;
    idle(6);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
